// File: rtl/load_store_unit.sv
// Purpose: memory-access stage; byte/half/word loads and stores over a word bus, load result extended.
// Latency: request at T, bus strobe at T+1, done at T+2 plus one cycle per waitrequest cycle.
// Backpressure: data_waitrequest freezes all bus outputs; stall holds the core while a transfer is in flight.
module load_store_unit #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        done,
    output logic        error,
    output logic [31:0] data_readdata,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic        data_waitrequest,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_addr;
    logic [1:0]         r_size;
    logic               r_signed;
    logic               r_is_read;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_error;
    logic [31:0]        r_rdata;

    logic               w_aligned;
    logic               w_legal;
    logic               w_timeout;
    logic [3:0]         w_be_req;
    logic [31:0]        w_wdata_req;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_val;

    // Request legality: one direction only, defined size, naturally aligned address.
    always_comb begin
        w_aligned = 1'b0;
        case (req_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~addr[0];
            2'd2:    w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        w_legal = req_valid && (req_read ^ req_write) && (req_size != 2'd3) && w_aligned;
    end

    // Byte lanes and lane-replicated store data for the incoming request.
    always_comb begin
        w_be_req    = 4'b1111;
        w_wdata_req = rt_data;
        case (req_size)
            2'd0: begin
                w_be_req    = 4'b0001 << addr[1:0];
                w_wdata_req = {4{rt_data[7:0]}};
            end
            2'd1: begin
                w_be_req    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_req = {2{rt_data[15:0]}};
            end
            default: begin
                w_be_req    = 4'b1111;
                w_wdata_req = rt_data;
            end
        endcase
    end

    // Pick the addressed lane(s) from the bus word and extend to 32 bits.
    always_comb begin
        w_byte     = mem_readdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = mem_readdata[7:0];
            2'd1:    w_byte = mem_readdata[15:8];
            2'd2:    w_byte = mem_readdata[23:16];
            default: w_byte = mem_readdata[31:24];
        endcase
        w_half     = r_addr[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        w_load_val = mem_readdata;
        case (r_size)
            2'd0:    w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
            2'd1:    w_load_val = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_val = mem_readdata;
        endcase
    end

    // Abort on the wait cycle that brings the consecutive-wait count up to the limit.
    assign w_timeout = (WAIT_LIMIT != 0) && data_waitrequest
                       && (r_cnt == CNT_W'(WAIT_LIMIT - 1));

    // Next state, strobes, stall and done pulse.
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_legal;
                if (w_legal) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                stall      = 1'b1;
                data_read  = r_is_read;
                data_write = ~r_is_read;
                if (!data_waitrequest) w_next = S_DONE;
                else if (w_timeout)    w_next = S_IDLE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Latched request, wait counter, error pulse and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_is_read <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_error   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_error <= 1'b0;
            if (r_state != S_ACCESS) r_cnt <= '0;
            if (r_state == S_IDLE && req_valid) begin
                if (w_legal) begin
                    r_addr    <= addr;
                    r_size    <= req_size;
                    r_signed  <= req_signed;
                    r_is_read <= req_read;
                    r_be      <= w_be_req;
                    r_wdata   <= w_wdata_req;
                end else begin
                    r_error   <= 1'b1;
                end
            end
            if (r_state == S_ACCESS) begin
                if (data_waitrequest) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_timeout) r_error <= 1'b1;
                end else if (r_is_read) begin
                    r_rdata <= w_load_val;
                end
            end
        end
    end

    assign error           = r_error;
    assign data_readdata   = r_rdata;
    assign data_address    = {r_addr[31:2], 2'b00};
    assign data_byteenable = r_be;
    assign data_writedata  = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] rt_data = '0;
    logic        data_waitrequest = 1'b0;
    logic [31:0] mem_readdata = '0;
    logic        stall, done, error, data_read, data_write;
    logic [31:0] data_readdata, data_address, data_writedata;
    logic [3:0]  data_byteenable;

    always #5 clk = ~clk;

    load_store_unit #(.WAIT_LIMIT(WL), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed),
        .addr(addr), .rt_data(rt_data),
        .stall(stall), .done(done), .error(error),
        .data_readdata(data_readdata), .data_address(data_address),
        .data_read(data_read), .data_write(data_write),
        .data_byteenable(data_byteenable), .data_writedata(data_writedata),
        .data_waitrequest(data_waitrequest), .mem_readdata(mem_readdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic bit f_legal(input bit rv, input bit rd, input bit wr,
                                   input logic [1:0] sz, input logic [31:0] a);
        if (!rv || (rd == wr) || sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [31:0] f_ext(input logic [31:0] mem, input int off,
                                          input int sz, input bit sg);
        logic [31:0] v;
        if (sz == 2) return mem;
        v = mem >> (8 * off);
        if (sz == 0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    function automatic logic [3:0] f_be(input int sz, input int off);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wd(input int sz, input logic [31:0] rt);
        if (sz == 0) return (rt & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    bit          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rd = 1'b0, m_sgn = 1'b0;
    logic [31:0] m_rdata = '0, m_addr = '0, m_rt = '0;
    int          m_size = 0, m_waits = 0;

    always @(posedge clk) begin : p_model
        bit nd, ne;
        nd = 1'b0;
        ne = 1'b0;
        if (reset) begin
            m_busy  = 1'b0;
            m_rdata = '0;
            m_waits = 0;
        end else if (m_busy) begin
            if (!data_waitrequest) begin
                if (m_rd) m_rdata = f_ext(mem_readdata, int'(m_addr % 4), m_size, m_sgn);
                m_busy = 1'b0;
                nd = 1'b1;
            end else begin
                m_waits++;
                if (WL != 0 && m_waits >= WL) begin
                    m_busy = 1'b0;
                    ne = 1'b1;
                end
            end
        end else if (!m_done && req_valid) begin
            if (f_legal(req_valid, req_read, req_write, req_size, addr)) begin
                m_busy = 1'b1; m_waits = 0; m_rd = req_read; m_sgn = req_signed;
                m_addr = addr; m_rt = rt_data; m_size = int'(req_size);
            end else begin
                ne = 1'b1;
            end
        end
        m_done = nd;
        m_err  = ne;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_stall", stall,
                m_busy || (!m_done && f_legal(req_valid, req_read, req_write, req_size, addr)));
            chk("cmp_read",  data_read,  m_busy && m_rd);
            chk("cmp_write", data_write, m_busy && !m_rd);
            chk("cmp_done",  done,  m_done);
            chk("cmp_error", error, m_err);
            chk("cmp_rdata", data_readdata, m_rdata);
            chk("cmp_done_error_excl", done & error, 1'b0);
            if (m_busy) begin
                chk("cmp_addr", data_address, m_addr & ~32'h3);
                chk("cmp_be",   data_byteenable, f_be(m_size, int'(m_addr % 4)));
                chk("cmp_wd",   data_writedata, f_wd(m_size, m_rt));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] rt, output logic st_t);
        @(posedge clk); #1;
        req_read = rd; req_write = wr; req_size = sz; req_signed = sg;
        addr = a; rt_data = rt; req_valid = 1'b1;
        @(negedge clk);
        st_t = stall;
        @(posedge clk); #1;
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cyc);
        bit seen = 1'b0;
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                cyc = i;
                break;
            end
        end
        chk(name, seen, 1'b1);
    endtask

    logic st;
    int   cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {stall, done, error, data_read, data_write}, 5'b0);
        chk("rst_rdata", data_readdata, 32'h0);
        chk("rst_addr", data_address, 32'h0);
        chk("rst_be_wd", {data_byteenable, data_writedata[27:0]}, 32'h0);

        // 1: LW, no wait
        mem_readdata = 32'hDEADBEEF;
        issue(1, 0, 2'd2, 0, 32'h100, 32'h0, st);
        chk("lw_stall_T", st, 1'b1);
        @(negedge clk);
        chk("lw_read_T1", data_read, 1'b1);
        chk("lw_addr_T1", data_address, 32'h100);
        chk("lw_be_T1", data_byteenable, 4'hF);
        chk("lw_stall_T1", stall, 1'b1);
        @(negedge clk);
        chk("lw_done_T2", done, 1'b1);
        chk("lw_stall_T2", stall, 1'b0);
        chk("lw_rdata", data_readdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("lw_done_pulse", done, 1'b0);

        // 2: byte/half loads with extension
        mem_readdata = 32'h80FF1234;
        issue(1, 0, 2'd0, 1, 32'h103, 32'h0, st);
        wait_done("lb_done", cyc);
        chk("lb_lat", cyc, 1);
        chk("lb_rdata", data_readdata, 32'hFFFFFF80);
        chk("lb_model", m_rdata, 32'hFFFFFF80);
        issue(1, 0, 2'd0, 0, 32'h103, 32'h0, st);
        wait_done("lbu_done", cyc);
        chk("lbu_rdata", data_readdata, 32'h00000080);
        chk("lbu_model", m_rdata, 32'h00000080);
        issue(1, 0, 2'd1, 1, 32'h102, 32'h0, st);
        wait_done("lh_done", cyc);
        chk("lh_rdata", data_readdata, 32'hFFFF80FF);
        chk("lh_model", m_rdata, 32'hFFFF80FF);

        // 3: SB with 3 wait cycles
        data_waitrequest = 1'b1;
        issue(0, 1, 2'd0, 0, 32'h201, 32'h000000A5, st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sb_write", data_write, 1'b1);
            chk("sb_be", data_byteenable, 4'b0010);
            chk("sb_wd", data_writedata, 32'hA5A5A5A5);
            chk("sb_addr", data_address, 32'h200);
            chk("sb_no_done", done, 1'b0);
        end
        @(posedge clk); #1 data_waitrequest = 1'b0;
        @(negedge clk);
        chk("sb_write_T4", data_write, 1'b1);
        chk("sb_no_done_T4", done, 1'b0);
        @(negedge clk);
        chk("sb_done_T5", done, 1'b1);
        chk("sb_rdata_kept", data_readdata, 32'hFFFF80FF);

        // 4: illegal requests
        issue(1, 0, 2'd2, 0, 32'h102, 32'h0, st);
        chk("ill_mis_stall", st, 1'b0);
        @(negedge clk);
        chk("ill_mis_err", error, 1'b1);
        chk("ill_mis_nostrobe", data_read, 1'b0);
        issue(1, 1, 2'd2, 0, 32'h100, 32'h0, st);
        @(negedge clk);
        chk("ill_rw_err", error, 1'b1);
        issue(1, 0, 2'd3, 0, 32'h100, 32'h0, st);
        @(negedge clk);
        chk("ill_sz_err", error, 1'b1);
        chk("ill_sz_nostrobe", data_read, 1'b0);

        // 5: timeout after WL wait cycles, then a normal LW
        data_waitrequest = 1'b1;
        issue(1, 0, 2'd2, 0, 32'h300, 32'h0, st);
        for (int k = 0; k < WL; k++) begin
            @(negedge clk);
            chk("to_strobe", data_read, 1'b1);
            chk("to_no_err", error, 1'b0);
        end
        @(negedge clk);
        chk("to_err", error, 1'b1);
        chk("to_strobe_off", data_read, 1'b0);
        chk("to_no_done", done, 1'b0);
        chk("to_rdata_kept", data_readdata, 32'hFFFF80FF);
        data_waitrequest = 1'b0;
        mem_readdata = 32'h11223344;
        issue(1, 0, 2'd2, 0, 32'h104, 32'h0, st);
        wait_done("to_next_done", cyc);
        chk("to_next_rdata", data_readdata, 32'h11223344);

        // 6: reset during ACCESS
        data_waitrequest = 1'b1;
        issue(1, 0, 2'd2, 0, 32'h400, 32'h0, st);
        @(negedge clk);
        chk("rs_strobe", data_read, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        data_waitrequest = 1'b0;
        @(negedge clk);
        chk("rs_ctrl", {stall, done, error, data_read, data_write}, 5'b0);
        chk("rs_rdata", data_readdata, 32'h0);
        chk("rs_bus", data_address | data_writedata | {28'h0, data_byteenable}, 32'h0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the datapath.
- Consumes the ALU result as the effective address and the rt register value as store data.
- Runs byte/half/word loads and stores over a word-wide data bus with a waitrequest handshake, and returns the extended load result to the datapath's data_readdata input.
- Stalls the core while a transfer is in flight; flags misaligned or illegal requests.

Parameters:
WAIT_LIMIT, 0, max consecutive waitrequest cycles before abort; 0 disables the timeout
CNT_W, 16, width of the wait counter; WAIT_LIMIT must be < 2^CNT_W

Ports:
clk  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  access request from the core this cycle
req_read  in  1  load request
req_write  in  1  store request
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_signed  in  1  sign-extend loads (LB/LH); 0 zero-extends (LBU/LHU)
addr  in  32  effective address (alu_out)
rt_data  in  32  store source (read_data_1)
stall  out  1  core must hold the current instruction
done  out  1  one-cycle pulse when the access completes
error  out  1  one-cycle pulse on a misaligned, illegal or timed-out request
data_readdata  out  32  extended load result, registered
data_address  out  32  word-aligned bus address (addr[31:2],2'b00)
data_read  out  1  bus read strobe
data_write  out  1  bus write strobe
data_byteenable  out  4  active byte lanes
data_writedata  out  32  lane-replicated store data
data_waitrequest  in  1  slave not ready; hold all bus outputs
mem_readdata  in  32  bus read data, valid when data_read=1 and data_waitrequest=0

Behaviour:
- Byte lanes: lane k = bits[8k+7:8k] holds byte at address offset k (little-endian lanes).
- Reset values: all outputs 0, state IDLE, wait counter 0.
- FSM states:
  - IDLE
    - Request is legal when: req_valid=1, exactly one of req_read/req_write is 1, req_size!=3, and the address is aligned (half: addr[0]=0; word: addr[1:0]=0).
    - On a legal request: latch addr, size, signed, read/write and rt_data, then go to ACCESS.
    - On req_valid with an illegal request: error=1 next cycle, stay IDLE, no bus activity.
  - ACCESS
    - data_read or data_write is 1.
    - Address, byteenable and writedata come from latched values and are stable while waitrequest=1.
    - When waitrequest=0: sample mem_readdata (loads), go to DONE.
    - Each waitrequest=1 cycle increments the counter.
    - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT: drop the strobes, error=1, go to IDLE, and leave data_readdata unchanged.
  - DONE
    - done=1 for one cycle; strobes 0; unconditionally go to IDLE and clear the counter.
    - req_valid is ignored in DONE.
- stall (combinational):
  - 1 in ACCESS.
  - 1 in IDLE when a legal request is present.
  - 0 in DONE and in all other cases.
- Latency: request cycle T, strobe at T+1. With waitrequest=0 at T+1, done=1 at T+2. Each waitrequest cycle adds 1.
- Byteenable by offset o=addr[1:0]:
  - byte: 1<<o.
  - half: 4'b0011 (o=0) or 4'b1100 (o=2).
  - word: 4'b1111.
- Writedata:
  - byte: {4{rt[7:0]}}.
  - half: {2{rt[15:0]}}.
  - word: rt.
- Load extraction: select the lane(s) by offset, then sign-extend (req_signed=1) or zero-extend to 32 bits. Word loads pass through.
- data_readdata:
  - Updates only on completion of a load.
  - Holds its value through stores, errors and idle cycles.
  - Stores never modify it.
- Reset mid-operation: next edge returns to IDLE and drops the strobes; the transfer is abandoned with no done and no error.
- done and error are never 1 in the same cycle.

Test Plan:
1. LW addr=0x100, mem_readdata=0xDEADBEEF, no wait → data_read at T+1 with address 0x100 and byteenable 1111; done at T+2; data_readdata=0xDEADBEEF; stall high at T and T+1 only.
2. LB addr=0x103, mem_readdata=0x80FF1234:
   - signed → data_readdata=0xFFFFFF80.
   - LBU same address → 0x00000080.
   - LH addr=0x102 signed → 0xFFFF80FF.
3. SB addr=0x201, rt_data=0x000000A5, waitrequest high 3 cycles → byteenable 0010, writedata 0xA5A5A5A5, outputs stable during the wait, done 4 cycles after the strobe, data_readdata unchanged.
4. Illegal requests:
   - LW addr=0x102 → error pulse, no strobe, stall 0.
   - req_read=req_write=1 → error.
   - req_size=3 → error.
5. WAIT_LIMIT=4, waitrequest stuck at 1 → strobe for 4 cycles, then error pulse, IDLE; a following legal LW completes normally.
6. reset asserted during ACCESS with waitrequest=1 → next cycle strobes 0, stall 0, no done or error, all outputs at reset values.
